kpn_fifo_channel: RTL and testbench
===================================

# kpn_fifo_channel

Bounded FIFO channel carrying 16-bit fixed-point tokens between two KPN process modules. It sits directly downstream of `delay_module`, capturing `output_1` whenever that stage raises `wr`, and feeds the next process, which pulls tokens with `rd`. It adds occupancy status and sticky overflow/underflow error flags so network deadlock or token loss is visible to the testbench.

## Interface
- `DEPTH`, default 8: number of token slots. Must be a power of two, ≥ 2. Internal `AW = log2(DEPTH)`.
- `WIDTH`, default 16: token width in bits (Q-format passthrough, never interpreted).
- `clk` input 1: single clock, all state on rising edge.
- `rst_n` input 1: asynchronous, active-low reset.
- `wr` input 1: producer write strobe. Samples `entry_1` at this edge.
- `entry_1` input WIDTH: token from producer (`delay_module.output_1`).
- `rd` input 1: consumer read strobe.
- `output_1` output WIDTH: registered token delivered by last accepted read.
- `out_valid` output 1: one-cycle pulse, `output_1` holds a freshly read token.
- `full` output 1: count == DEPTH.
- `empty` output 1: count == 0.
- `count` output AW+1: current occupancy, 0..DEPTH.
- `overflow` output 1: sticky, write attempted while full.
- `underflow` output 1: sticky, read attempted while empty.

## Operation
- Storage: DEPTH×WIDTH register array, write pointer `wp` and read pointer `rp`, each AW bits, wrapping naturally from DEPTH-1 to 0.
- Accepted write: `wr && (!full || rd)`. Stores `entry_1` at `mem[wp]`, `wp <= wp+1`.
- Accepted read: `rd && !empty`. `output_1 <= mem[rp]`, `rp <= rp+1`, `out_valid <= 1`. Otherwise `out_valid <= 0` and `output_1` holds its value.
- Count: +1 on write-only, −1 on read-only, unchanged on both or neither.
- Simultaneous `wr` and `rd`:
  - When neither full nor empty: both accepted, count unchanged.
  - When full: both accepted. The read frees a slot in the same edge, so no overflow.
  - When empty: write accepted, read rejected, count becomes 1, `underflow` set. There is no bypass: the token is never delivered in the same cycle it is written.
- Rejected write (`wr && full && !rd`): data dropped, pointers unchanged, `overflow <= 1`.
- Rejected read (`rd && empty`): `underflow <= 1`, `output_1` unchanged.
- `overflow` and `underflow` clear only on reset.
- `full` and `empty` are combinational decodes of the registered `count`.

## Timing
- Reset, asynchronous on `rst_n` low, immediate:
  - `wp = rp = 0`, `count = 0`, `empty = 1`, `full = 0`
  - `output_1 = 0`, `out_valid = 0`, `overflow = 0`, `underflow = 0`
  - Memory contents are not reset.
- Reset release is synchronous to the next `clk` edge. The first edge with `rst_n` high may accept a write.
- Write latency: token written at edge N is readable by `rd` at edge N+1, and appears on `output_1` after edge N+1. Minimum write-to-output latency is 2 edges.
- Read latency: `rd` sampled at edge N → `output_1` and `out_valid` valid after edge N, for one cycle.
- Status: `count`, `full`, `empty` and the error flags reflect the edge just taken.
- Reset mid-operation: all buffered tokens are discarded, and any in-flight `out_valid` drops immediately.
- Throughput: one write and one read per cycle sustained, at any occupancy.

## Test plan
1. Reset then idle: `rst_n` = 0 for 2 cycles, release → `empty=1`, `full=0`, `count=0`, `output_1=0x0000`, no flags set.
2. Fill and drain: write 0x0001..0x0008 on consecutive cycles → `full=1`, `count=8`. Then 8 reads → `output_1` sequence 0x0001..0x0008, each with an `out_valid` pulse, ending with `empty=1`.
3. Overflow and full-simultaneous:
   - At full, `wr` with 0x00AA, `rd`=0 → `overflow=1`, `count=8`, 0x00AA never appears.
   - Then `wr`=0x00BB together with `rd` → `output_1` = oldest token, `count=8`, no new error.
4. Underflow and empty-simultaneous:
   - At empty, `rd` alone → `underflow=1`, `out_valid=0`.
   - Then `wr`=0x1234 with `rd` → `count=1`, `out_valid=0`. The next `rd` gives `output_1=0x1234`.
5. Wrap-around: 20 cycles of interleaved write/read with occupancy between 1 and 7, driving `wp`/`rp` past DEPTH twice → output order matches input order exactly, with no flags set.
6. Reset mid-operation and delay hookup:
   - With `count=5`, assert `rst_n` low between edges → all outputs return to reset values immediately. After release, reads set `underflow`.
   - Drive from `delay_module` with DELAY_NUMBER=4 → the first accepted token equals the first non-zero delayed sample.

Source files
------------

// File: rtl/kpn_fifo_channel.sv
// kpn_fifo_channel: bounded FIFO between two KPN process modules.
// Registered read data with a one-cycle out_valid pulse, occupancy status,
// and sticky overflow/underflow flags that expose token loss or deadlock.
module kpn_fifo_channel #(
  parameter int DEPTH = 8,
  parameter int WIDTH = 16,
  localparam int AW   = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             wr,
  input  logic [WIDTH-1:0] entry_1,
  input  logic             rd,
  output logic [WIDTH-1:0] output_1,
  output logic             out_valid,
  output logic             full,
  output logic             empty,
  output logic [AW:0]      count,
  output logic             overflow,
  output logic             underflow
);

  localparam logic [AW:0] FULL_COUNT = (AW + 1)'(DEPTH);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [AW-1:0]    r_wp;
  logic [AW-1:0]    r_rp;
  logic [AW:0]      r_count;
  logic [WIDTH-1:0] r_output;
  logic             r_out_valid;
  logic             r_overflow;
  logic             r_underflow;

  logic             w_full;
  logic             w_empty;
  logic             w_wr_ok;
  logic             w_rd_ok;

  // Status decodes of the registered occupancy.
  assign w_full  = (r_count == FULL_COUNT);
  assign w_empty = (r_count == '0);

  // A write at full is still accepted when a read frees a slot on the same
  // edge. A read at empty is always rejected: there is no write-to-read bypass.
  assign w_wr_ok = wr && (!w_full || rd);
  assign w_rd_ok = rd && !w_empty;

  // Token storage.
  // NOTE: the array has no reset; stale slots are unreachable because the
  // pointers and count are reset, so a reset here would only add muxing.
  always_ff @(posedge clk) begin
    if (w_wr_ok) begin
      r_mem[r_wp] <= entry_1;
    end
  end

  // Pointers, occupancy, registered read data and sticky error flags.
  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values, independent of statement order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wp        <= '0;
      r_rp        <= '0;
      r_count     <= '0;
      r_output    <= '0;
      r_out_valid <= 1'b0;
      r_overflow  <= 1'b0;
      r_underflow <= 1'b0;
    end else begin
      if (w_wr_ok) begin
        r_wp <= r_wp + 1'b1;
      end
      if (w_rd_ok) begin
        r_output <= r_mem[r_rp];
        r_rp     <= r_rp + 1'b1;
      end
      r_out_valid <= w_rd_ok;

      case ({w_wr_ok, w_rd_ok})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase

      if (wr && w_full && !rd) begin
        r_overflow <= 1'b1;
      end
      if (rd && w_empty) begin
        r_underflow <= 1'b1;
      end
    end
  end

  assign output_1  = r_output;
  assign out_valid = r_out_valid;
  assign full      = w_full;
  assign empty     = w_empty;
  assign count     = r_count;
  assign overflow  = r_overflow;
  assign underflow = r_underflow;

endmodule

// File: tb/tb_kpn_fifo_channel.sv
// Directed testbench for kpn_fifo_channel (DEPTH=8, WIDTH=16).
// Inputs change on the falling edge; outputs are sampled 1 ns after the rising edge.
module tb_kpn_fifo_channel;

  logic        clk;
  logic        rst_n;
  logic        wr;
  logic [15:0] entry_1;
  logic        rd;
  logic [15:0] output_1;
  logic        out_valid;
  logic        full;
  logic        empty;
  logic [3:0]  count;
  logic        overflow;
  logic        underflow;

  int n_total;
  int n_bad;

  kpn_fifo_channel #(.DEPTH(8), .WIDTH(16)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .wr        (wr),
    .entry_1   (entry_1),
    .rd        (rd),
    .output_1  (output_1),
    .out_valid (out_valid),
    .full      (full),
    .empty     (empty),
    .count     (count),
    .overflow  (overflow),
    .underflow (underflow)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        wr;
    logic        rd;
    logic [15:0] din;
    logic [3:0]  cnt;
    logic        full;
    logic        empty;
    logic        vld;
    logic [15:0] dout;
    logic        ovf;
    logic        unf;
  } vec_t;

  vec_t tbl [21];

  function automatic vec_t mk(input logic w, input logic r, input logic [15:0] d,
                              input logic [3:0] c, input logic f, input logic e,
                              input logic v, input logic [15:0] o,
                              input logic ov, input logic un);
    vec_t t;
    t.wr = w; t.rd = r; t.din = d; t.cnt = c; t.full = f; t.empty = e;
    t.vld = v; t.dout = o; t.ovf = ov; t.unf = un;
    return t;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Drive inputs at the falling edge, then wait until just after the rising edge.
  task automatic step(input logic w, input logic r, input logic [15:0] d);
    @(negedge clk);
    wr = w; rd = r; entry_1 = d;
    @(posedge clk);
    #1;
  endtask

  task automatic check_reset_state(input string tag);
    check({tag, "_count"}, 32'(count), 0);
    check({tag, "_empty"}, 32'(empty), 1);
    check({tag, "_full"}, 32'(full), 0);
    check({tag, "_out"}, 32'(output_1), 0);
    check({tag, "_vld"}, 32'(out_valid), 0);
    check({tag, "_ovf"}, 32'(overflow), 0);
    check({tag, "_unf"}, 32'(underflow), 0);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0; wr = 1'b0; rd = 1'b0; entry_1 = '0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
  endtask

  logic [15:0] model_q [$];
  logic [15:0] exp_tok;

  initial begin
    n_total = 0;
    n_bad   = 0;
    rst_n   = 1'b0;
    wr      = 1'b0;
    rd      = 1'b0;
    entry_1 = '0;

    // Fill, overflow at full, simultaneous at full, drain, underflow,
    // simultaneous at empty, then deliver the token written at empty.
    for (int i = 0; i < 8; i++) begin
      tbl[i] = mk(1, 0, 16'(i + 1), 4'(i + 1), (i == 7), 0, 0, 16'h0000, 0, 0);
    end
    tbl[8] = mk(1, 0, 16'h00AA, 4'd8, 1, 0, 0, 16'h0000, 1, 0);
    tbl[9] = mk(1, 1, 16'h00BB, 4'd8, 1, 0, 1, 16'h0001, 1, 0);
    for (int i = 10; i < 17; i++) begin
      tbl[i] = mk(0, 1, 16'h0000, 4'(17 - i), 0, 0, 1, 16'(i - 8), 1, 0);
    end
    tbl[17] = mk(0, 1, 16'h0000, 4'd0, 0, 1, 1, 16'h00BB, 1, 0);
    tbl[18] = mk(0, 1, 16'h0000, 4'd0, 0, 1, 0, 16'h00BB, 1, 1);
    tbl[19] = mk(1, 1, 16'h1234, 4'd1, 0, 0, 0, 16'h00BB, 1, 1);
    tbl[20] = mk(0, 1, 16'h0000, 4'd0, 0, 1, 1, 16'h1234, 1, 1);

    // Reset then idle.
    repeat (2) @(negedge clk);
    check_reset_state("in_reset");
    rst_n = 1'b1;
    step(0, 0, 16'h0);
    check_reset_state("idle");

    // Table-driven vectors.
    foreach (tbl[i]) begin
      step(tbl[i].wr, tbl[i].rd, tbl[i].din);
      check($sformatf("v%0d_count", i), 32'(count), 32'(tbl[i].cnt));
      check($sformatf("v%0d_full", i), 32'(full), 32'(tbl[i].full));
      check($sformatf("v%0d_empty", i), 32'(empty), 32'(tbl[i].empty));
      check($sformatf("v%0d_vld", i), 32'(out_valid), 32'(tbl[i].vld));
      check($sformatf("v%0d_out", i), 32'(output_1), 32'(tbl[i].dout));
      check($sformatf("v%0d_ovf", i), 32'(overflow), 32'(tbl[i].ovf));
      check($sformatf("v%0d_unf", i), 32'(underflow), 32'(tbl[i].unf));
    end

    // Wrap-around: prime 3 tokens, 20 cycles of write+read, drain 3.
    // 23 writes take both pointers past DEPTH twice.
    do_reset();
    model_q.delete();
    for (int k = 0; k < 3; k++) begin
      step(1, 0, 16'h0100 + 16'(k));
      model_q.push_back(16'h0100 + 16'(k));
    end
    for (int k = 3; k < 23; k++) begin
      step(1, 1, 16'h0100 + 16'(k));
      model_q.push_back(16'h0100 + 16'(k));
      exp_tok = model_q.pop_front();
      check($sformatf("wrap%0d_vld", k), 32'(out_valid), 1);
      check($sformatf("wrap%0d_out", k), 32'(output_1), 32'(exp_tok));
      check($sformatf("wrap%0d_count", k), 32'(count), 3);
    end
    for (int k = 0; k < 3; k++) begin
      step(0, 1, 16'h0);
      exp_tok = model_q.pop_front();
      check($sformatf("drain%0d_out", k), 32'(output_1), 32'(exp_tok));
      check($sformatf("drain%0d_vld", k), 32'(out_valid), 1);
    end
    check("wrap_empty", 32'(empty), 1);
    check("wrap_ovf", 32'(overflow), 0);
    check("wrap_unf", 32'(underflow), 0);

    // Reset mid-operation: 6 writes, 1 read leaves count=5 with out_valid high.
    do_reset();
    for (int k = 0; k < 6; k++) begin
      step(1, 0, 16'h0A00 + 16'(k));
    end
    step(0, 1, 16'h0);
    check("mid_count", 32'(count), 5);
    check("mid_vld", 32'(out_valid), 1);
    check("mid_out", 32'(output_1), 32'h0A00);
    #2;
    rst_n = 1'b0;
    wr = 1'b0; rd = 1'b0;
    #1;
    check_reset_state("async_rst");
    @(negedge clk);
    rst_n = 1'b1;
    step(0, 1, 16'h0);
    check("post_rst_unf", 32'(underflow), 1);
    check("post_rst_vld", 32'(out_valid), 0);
    check("post_rst_out", 32'(output_1), 0);
    check("post_rst_empty", 32'(empty), 1);

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
